// File: rtl/mpc_seq_pkg.sv
// Shared constants, state encoding and operand payload for the MPC operand sequencer.
package mpc_seq_pkg;

  localparam int unsigned IN_W     = 32;
  localparam int unsigned OPER_W   = 21;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned NUM_OPER = 3;

  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_OPER - 1);
  localparam logic [OPER_W-1:0] SAT_MAX  = {1'b0, {(OPER_W-1){1'b1}}};
  localparam logic [OPER_W-1:0] SAT_MIN  = {1'b1, {(OPER_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPER_W-1:0] d2;
    logic [OPER_W-1:0] d1;
    logic [OPER_W-1:0] d0;
  } oper_set_t;

endpackage

// File: rtl/mpc_operand_narrow.sv
// Combinational IN_W -> OPER_W operand narrowing.
// MPC_OPERAND_SAT_EN selects signed saturation; otherwise plain truncation.
module mpc_operand_narrow
  import mpc_seq_pkg::*;
(
  input  logic [IN_W-1:0]   i_raw,
  output logic [OPER_W-1:0] o_narrow_c
);

`ifdef MPC_OPERAND_SAT_EN
  logic w_sign;
  logic w_ovf;

  // Value fits when every bit above the narrowed sign bit matches the source sign.
  assign w_sign     = i_raw[IN_W-1];
  assign w_ovf      = (i_raw[IN_W-1:OPER_W-1] != {(IN_W-OPER_W+1){w_sign}});
  assign o_narrow_c = !w_ovf ? i_raw[OPER_W-1:0] : (w_sign ? SAT_MIN : SAT_MAX);
`else
  logic w_unused_hi;

  assign w_unused_hi = ^i_raw[IN_W-1:OPER_W];
  assign o_narrow_c  = i_raw[OPER_W-1:0];
`endif

endmodule

// File: rtl/mpc_operand_sequencer.sv
// Captures three operands on ap_start, narrows them and issues mux selects 0..2 under valid/ready.
// Build option: MPC_OPERAND_SAT_EN (saturating narrow, see mpc_operand_narrow).
module mpc_operand_sequencer
  import mpc_seq_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [IN_W-1:0]   in0,
  input  logic [IN_W-1:0]   in1,
  input  logic [IN_W-1:0]   in2,
  output logic [OPER_W-1:0] din0_o,
  output logic [OPER_W-1:0] din1_o,
  output logic [OPER_W-1:0] din2_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              sel_vld_o,
  input  logic              sel_rdy_i
);

  state_t            r_state, w_state;
  oper_set_t         r_din, w_din;
  logic [SEL_W-1:0]  r_sel, w_sel;
  logic              r_vld, w_vld;
  logic              r_done, w_done;
  logic              r_idle, w_idle;
  logic              w_ready;
  logic [OPER_W-1:0] w_nar0, w_nar1, w_nar2;

  mpc_operand_narrow u_narrow0 (.i_raw(in0), .o_narrow_c(w_nar0));
  mpc_operand_narrow u_narrow1 (.i_raw(in1), .o_narrow_c(w_nar1));
  mpc_operand_narrow u_narrow2 (.i_raw(in2), .o_narrow_c(w_nar2));

  // State and output registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_din   <= '0;
      r_sel   <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_din   <= w_din;
      r_sel   <= w_sel;
      r_vld   <= w_vld;
      r_done  <= w_done;
      r_idle  <= w_idle;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_din   = r_din;
    w_sel   = r_sel;
    w_vld   = r_vld;
    w_done  = 1'b0;
    w_idle  = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_idle = 1'b1;
        if (ap_start) begin
          w_ready = 1'b1;
          w_din   = '{d2: w_nar2, d1: w_nar1, d0: w_nar0};
          w_sel   = '0;
          w_vld   = 1'b1;
          w_idle  = 1'b0;
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_rdy_i) begin
          if (r_sel == SEL_LAST) begin
            w_vld   = 1'b0;
            w_done  = 1'b1;
            w_state = DONE;
          end else begin
            w_sel = SEL_W'(r_sel + SEL_W'(1));
          end
        end
      end
      DONE: begin
        w_idle  = 1'b1;
        w_state = IDLE;
      end
      default: begin
        w_vld   = 1'b0;
        w_idle  = 1'b1;
        w_state = IDLE;
      end
    endcase
  end

  // ap_ready is the capture strobe itself, so it is asserted in the cycle ap_start is sampled.
  assign ap_ready  = w_ready & ~ap_rst;
  assign ap_done   = r_done;
  assign ap_idle   = r_idle;
  assign din0_o    = r_din.d0;
  assign din1_o    = r_din.d1;
  assign din2_o    = r_din.d2;
  assign sel_o     = r_sel;
  assign sel_vld_o = r_vld;

endmodule

// File: tb/tb_mpc_operand_sequencer.sv
// Self-checking bench for mpc_operand_sequencer: transaction-level model, per-cycle compare, directed and random stimulus.
module tb_mpc_operand_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic [31:0] in0, in1, in2;
  logic [20:0] din0_o, din1_o, din2_o;
  logic [1:0]  sel_o;
  logic        sel_vld_o;
  logic        sel_rdy_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Model: selects still owed downstream, done pulse, current select, held operands.
  int          m_left = 0;
  bit          m_done = 1'b0;
  int          m_sel  = 0;
  logic [20:0] m_din [3] = '{21'h0, 21'h0, 21'h0};

  logic [31:0] bnd [6] = '{32'h000FFFFF, 32'hFFF00000, 32'h00100000,
                           32'hFFEFFFFF, 32'h7FFFFFFF, 32'h80000000};

  mpc_operand_sequencer dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .in0(in0), .in1(in1), .in2(in2),
    .din0_o(din0_o), .din1_o(din1_o), .din2_o(din2_o), .sel_o(sel_o),
    .sel_vld_o(sel_vld_o), .sel_rdy_i(sel_rdy_i)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [20:0] narrow(input logic [31:0] x);
    int v;
    v = int'($signed(x));
`ifdef MPC_OPERAND_SAT_EN
    if (v > 1048575)  return 21'h0FFFFF;
    if (v < -1048576) return 21'h100000;
`endif
    return x[20:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ap_clk);
      if (ap_done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=no_done required=ap_done within %0d cycles", budget);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(3))
      0:       return 32'($signed(21'($urandom)));
      1:       return bnd[$urandom_range(5)];
      default: return $urandom;
    endcase
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(negedge ap_clk) if (ap_done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference model advance on each rising edge.
  always @(posedge ap_clk) begin
    if (ap_rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_sel  = 0;
      m_din  = '{21'h0, 21'h0, 21'h0};
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (sel_rdy_i) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
        else             m_sel++;
      end
    end else if (ap_start) begin
      m_din  = '{narrow(in0), narrow(in1), narrow(in2)};
      m_sel  = 0;
      m_left = 3;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge ap_clk) begin
    if (chk_en) begin
      check("ap_idle",   32'(ap_idle),   32'(m_left == 0 && !m_done));
      check("ap_done",   32'(ap_done),   32'(m_done));
      check("ap_ready",  32'(ap_ready),  32'(m_left == 0 && !m_done && ap_start && !ap_rst));
      check("sel_vld_o", 32'(sel_vld_o), 32'(m_left > 0));
      check("sel_o",     32'(sel_o),     32'(m_sel));
      check("din0_o",    32'(din0_o),    32'(m_din[0]));
      check("din1_o",    32'(din1_o),    32'(m_din[1]));
      check("din2_o",    32'(din2_o),    32'(m_din[2]));
    end
  end

  initial begin
    int cap_c, done_c, rdy_c, d0;
    logic [31:0] v0, b0;
    ap_rst = 1'b1; ap_start = 1'b0; sel_rdy_i = 1'b1;
    in0 = 32'h0; in1 = 32'h0; in2 = 32'h0;
    tick; chk_en = 1'b1; tick; tick;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_vld",  32'(sel_vld_o), 32'd0);

    // Basic flow
    tick; in0 = 32'h00000005; in1 = 32'hFFFFFFFE; in2 = 32'h00012345; ap_start = 1'b1;
    @(negedge ap_clk);
    check("basic_ready", 32'(ap_ready), 32'd1);
    cap_c = cyc;
    tick; ap_start = 1'b0;
    @(negedge ap_clk);
    check("basic_first_vld", 32'(sel_vld_o), 32'd1);
    check("basic_first_sel", 32'(sel_o), 32'd0);
    wait_done(10);
    done_c = cyc;
    check("basic_len",  32'(done_c - cap_c), 32'd4);
    check("basic_din0", 32'(din0_o), 32'h000005);
    check("basic_din1", 32'(din1_o), 32'h1FFFFE);
    check("basic_din2", 32'(din2_o), 32'h012345);

    // Backpressure while sel_o=1
    tick; v0 = rand_val(); in0 = v0; in1 = rand_val(); in2 = rand_val(); ap_start = 1'b1;
    d0 = done_cnt;
    tick; ap_start = 1'b0;
    tick; sel_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      check("bp_sel",  32'(sel_o), 32'd1);
      check("bp_vld",  32'(sel_vld_o), 32'd1);
      check("bp_din0", 32'(din0_o), 32'(narrow(v0)));
      tick;
    end
    sel_rdy_i = 1'b1;
    @(negedge ap_clk);
    check("bp_resume_sel", 32'(sel_o), 32'd1);
    wait_done(10);
    tick;
    check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Back-to-back with ap_start held high
    in0 = rand_val(); in1 = rand_val(); in2 = rand_val(); ap_start = 1'b1;
    tick; b0 = rand_val(); in0 = b0; in1 = rand_val(); in2 = rand_val();
    wait_done(10);
    done_c = cyc;
    rdy_c = -100;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (ap_ready) begin rdy_c = cyc; break; end
    end
    check("b2b_gap", 32'(rdy_c - done_c), 32'd1);
    tick; ap_start = 1'b0;
    @(negedge ap_clk);
    check("b2b_din0", 32'(din0_o), 32'(narrow(b0)));
    wait_done(10);

    // Saturation / truncation boundaries
    tick; in0 = 32'h00200000; in1 = 32'hFFE00000; in2 = 32'h000FFFFF; ap_start = 1'b1;
    tick; ap_start = 1'b0;
    @(negedge ap_clk);
`ifdef MPC_OPERAND_SAT_EN
    check("sat_din0", 32'(din0_o), 32'h0FFFFF);
    check("sat_din1", 32'(din1_o), 32'h100000);
`else
    check("trunc_din0", 32'(din0_o), 32'h000000);
    check("trunc_din1", 32'(din1_o), 32'h000000);
`endif
    check("inrange_din2", 32'(din2_o), 32'h0FFFFF);
    wait_done(10);

    // ap_start ignored during ISSUE
    tick; in0 = 32'h00000111; ap_start = 1'b1;
    tick; ap_start = 1'b0; sel_rdy_i = 1'b0;
    tick; in0 = 32'h00000222; ap_start = 1'b1;
    @(negedge ap_clk);
    check("ign_ready", 32'(ap_ready), 32'd0);
    tick; ap_start = 1'b0;
    @(negedge ap_clk);
    check("ign_din0", 32'(din0_o), 32'h000111);
    sel_rdy_i = 1'b1;
    wait_done(10);

    // Reset mid-ISSUE with sel_o=1
    tick; ap_start = 1'b1;
    tick; ap_start = 1'b0;
    tick; sel_rdy_i = 1'b0;
    @(negedge ap_clk);
    check("rst_pre_sel", 32'(sel_o), 32'd1);
    d0 = done_cnt;
    tick; ap_rst = 1'b1;
    tick; tick; ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_mid_idle", 32'(ap_idle), 32'd1);
    check("rst_mid_vld",  32'(sel_vld_o), 32'd0);
    check("rst_mid_sel",  32'(sel_o), 32'd0);
    check("rst_mid_din0", 32'(din0_o), 32'd0);
    sel_rdy_i = 1'b1;
    repeat (5) tick;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Random traffic
    repeat (600) begin
      tick;
      ap_rst    = ($urandom_range(63) == 0);
      ap_start  = ($urandom_range(2) == 0);
      sel_rdy_i = ($urandom_range(3) != 0);
      in0 = rand_val(); in1 = rand_val(); in2 = rand_val();
    end
    tick; ap_rst = 1'b0; ap_start = 1'b0; sel_rdy_i = 1'b1;
    repeat (8) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
